axi_adapter_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI adapter request port (req/gnt/valid, single outstanding transaction) between NUM_PORTS requesters (e.g. I-cache refill, D-cache miss/writeback, PTW). It latches the winning requester for the whole transaction, muxes that requester's request fields to the adapter, and routes grant, completion, critical word and read data back. The arbiter owns the adapter ID field and checks returned IDs.

---
 rtl/axi_adapter_arbiter_pkg.sv | 26 ++
 rtl/axi_adapter_arbiter_rr_pick.sv | 30 +++
 rtl/axi_adapter_arbiter.sv | 160 ++++++++++++++++
 tb/tb_axi_adapter_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_adapter_arbiter_pkg.sv
// Shared types for the AXI adapter arbiter slice: the adapter request kind,
// the core's XLEN and the arbiter FSM state encoding.
package axi_adapter_arbiter_pkg;

  // Native word width of the core; critical word and addresses use it.
  localparam int unsigned XLEN = 64;

  // Kind of adapter request: one beat or a whole cache line.
  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Width of a port index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_adapter_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping
// modulo NUM_PORTS. Purely combinational.
module axi_adapter_arbiter_rr_pick
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  // Scan from the farthest candidate down to the pointer so the closest one wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_i) + i) % int'(NUM_PORTS));
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Shares one single-outstanding AXI adapter port between NUM_PORTS requesters.
// The winner is latched for the whole transaction; its request fields stay on
// the adapter through RESP because the adapter reads write beats from them.
module axi_adapter_arbiter
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned AXI_ID_WIDTH = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             type_i,
  input  logic [NUM_PORTS*XLEN-1:0]        addr_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*2-1:0]           size_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             valid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [XLEN-1:0]                  critical_word_o,
  output logic [NUM_PORTS-1:0]             critical_word_valid_o,
  output logic                             err_o,
  output logic                             ad_req_o,
  output logic                             ad_type_o,
  output logic [XLEN-1:0]                  ad_addr_o,
  output logic                             ad_we_o,
  output logic [DATA_WIDTH-1:0]            ad_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          ad_be_o,
  output logic [1:0]                       ad_size_o,
  output logic [AXI_ID_WIDTH-1:0]          ad_id_o,
  input  logic                             ad_gnt_i,
  input  logic                             ad_valid_i,
  input  logic [DATA_WIDTH-1:0]            ad_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]          ad_id_i,
  input  logic [XLEN-1:0]                  ad_cw_i,
  input  logic                             ad_cw_valid_i
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] sel_next;
  logic             id_ok;
  logic             resp_done;

  axi_adapter_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) i_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // The ID we issue is the port index, so a good response carries exactly that.
  assign id_ok    = (ad_id_i == AXI_ID_WIDTH'(sel_q));
  assign sel_next = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
  assign err_o    = err_q;

  // Request fields follow the latched winner outside IDLE, zero otherwise.
  always_comb begin
    ad_type_o  = 1'b0;
    ad_addr_o  = '0;
    ad_we_o    = 1'b0;
    ad_wdata_o = '0;
    ad_be_o    = '0;
    ad_size_o  = '0;
    ad_id_o    = '0;
    if (state_q != ARB_IDLE) begin
      ad_type_o  = type_i[sel_q];
      ad_addr_o  = addr_i[sel_q*XLEN +: XLEN];
      ad_we_o    = we_i[sel_q];
      ad_wdata_o = wdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
      ad_be_o    = be_i[sel_q*BE_W +: BE_W];
      ad_size_o  = size_i[sel_q*2 +: 2];
      ad_id_o    = AXI_ID_WIDTH'(sel_q);
    end
  end

  // Next-state logic and the one-hot pulses routed back to the winner.
  always_comb begin
    state_d               = state_q;
    sel_d                 = sel_q;
    rr_ptr_d              = rr_ptr_q;
    err_d                 = err_q;
    gnt_o                 = '0;
    valid_o               = '0;
    critical_word_valid_o = '0;
    rdata_o               = '0;
    critical_word_o       = '0;
    ad_req_o              = 1'b0;
    resp_done             = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // No transaction is open, so any response here is stray.
        if (ad_valid_i || ad_cw_valid_i) err_d = 1'b1;
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        ad_req_o = 1'b1;
        if (ad_gnt_i) begin
          gnt_o[sel_q] = 1'b1;
          state_d      = ARB_RESP;
          if (ad_cw_valid_i) begin
            critical_word_valid_o[sel_q] = 1'b1;
            critical_word_o              = ad_cw_i;
          end
          resp_done = ad_valid_i;
        end else if (ad_valid_i || ad_cw_valid_i) begin
          err_d = 1'b1;
        end
      end
      ARB_RESP: begin
        if (ad_cw_valid_i) begin
          critical_word_valid_o[sel_q] = 1'b1;
          critical_word_o              = ad_cw_i;
        end
        resp_done = ad_valid_i;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (resp_done) begin
      valid_o[sel_q] = 1'b1;
      rdata_o        = ad_rdata_i;
      rr_ptr_d       = sel_next;
      state_d        = ARB_IDLE;
      if (!id_ok) err_d = 1'b1;
    end
  end

  // State, winner, round-robin pointer and sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Bench for axi_adapter_arbiter: directed scenarios followed by randomized
// transactions, with a transaction-level round-robin reference model.
module tb_axi_adapter_arbiter;
  import axi_adapter_arbiter_pkg::*;

  localparam int NP  = 3;
  localparam int DW  = 256;
  localparam int IW  = 10;
  localparam int BW  = DW / 8;
  localparam int IXW = 2;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req_i, type_i, we_i;
  logic [NP*XLEN-1:0] addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP*BW-1:0]  be_i;
  logic [NP*2-1:0]   size_i;
  logic [NP-1:0]     gnt_o, valid_o, critical_word_valid_o;
  logic [DW-1:0]     rdata_o;
  logic [XLEN-1:0]   critical_word_o;
  logic              err_o;
  logic              ad_req_o, ad_type_o, ad_we_o;
  logic [XLEN-1:0]   ad_addr_o;
  logic [DW-1:0]     ad_wdata_o;
  logic [BW-1:0]     ad_be_o;
  logic [1:0]        ad_size_o;
  logic [IW-1:0]     ad_id_o;
  logic              ad_gnt_i, ad_valid_i, ad_cw_valid_i;
  logic [DW-1:0]     ad_rdata_i;
  logic [IW-1:0]     ad_id_i;
  logic [XLEN-1:0]   ad_cw_i;

  int total = 0;
  int bad = 0;
  int proto_viol = 0;
  int rr_m = 0;
  logic err_m = 1'b0;

  always #5 clk = ~clk;

  axi_adapter_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .type_i(type_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o),
    .critical_word_o(critical_word_o), .critical_word_valid_o(critical_word_valid_o),
    .err_o(err_o),
    .ad_req_o(ad_req_o), .ad_type_o(ad_type_o), .ad_addr_o(ad_addr_o), .ad_we_o(ad_we_o),
    .ad_wdata_o(ad_wdata_o), .ad_be_o(ad_be_o), .ad_size_o(ad_size_o), .ad_id_o(ad_id_o),
    .ad_gnt_i(ad_gnt_i), .ad_valid_i(ad_valid_i), .ad_rdata_i(ad_rdata_i),
    .ad_id_i(ad_id_i), .ad_cw_i(ad_cw_i), .ad_cw_valid_i(ad_cw_valid_i)
  );

  // A requester must hold req_i until it sees its grant.
  logic [NP-1:0] req_prev = '0;
  logic [NP-1:0] gnt_prev = '0;
  always @(posedge clk) begin
    if (rst_ni) begin
      for (int p = 0; p < NP; p++)
        if (req_prev[p] && !req_i[p] && !gnt_prev[p] && !gnt_o[p]) proto_viol++;
    end
    req_prev <= rst_ni ? req_i : '0;
    gnt_prev <= gnt_o;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [IXW-1:0] ix(input int p);
    return IXW'(p);
  endfunction

  task automatic set_port(input int p, input logic we);
    we_i[ix(p)]              = we;
    type_i[ix(p)]            = we;
    size_i[p*2 +: 2]         = 2'd3;
    addr_i[p*XLEN +: XLEN]   = {$urandom, $urandom};
    wdata_i[p*DW +: DW]      = rand_line();
    be_i[p*BW +: BW]         = $urandom;
  endtask

  task automatic clr_ad();
    ad_gnt_i = 1'b0; ad_valid_i = 1'b0; ad_cw_valid_i = 1'b0;
    ad_id_i = '0; ad_rdata_i = '0; ad_cw_i = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    clr_ad();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    req_i = '0;
    clr_ad();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    rr_m = 0;
    err_m = 1'b0;
    #1;
  endtask

  // Plays the adapter for one transaction expected to belong to port p.
  task automatic do_txn(input int p, input int gdly, input int vdly, input int cw_at,
                        input logic [IW-1:0] rid, input int exp_wait, input bit keep);
    int w;
    logic [DW-1:0] rd;
    logic [XLEN-1:0] cw;
    logic [NP-1:0] oh;
    oh = NP'(1) << p;
    w = 0;
    @(posedge clk); #1;
    clr_ad();
    chk("err_state", DW'(err_o), DW'(err_m));
    while (!ad_req_o && w < 20) begin
      w++;
      @(posedge clk); #1;
      clr_ad();
    end
    if (!ad_req_o) begin
      chk("req_timeout", DW'(ad_req_o), DW'(1));
      return;
    end
    if (exp_wait >= 0) chk("arb_latency", DW'(w), DW'(exp_wait));
    for (int k = 0; k <= gdly; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ad_gnt_i   = (k == gdly);
      ad_valid_i = (k == gdly) && (vdly == 0);
      ad_id_i    = rid;
      rd         = rand_line();
      ad_rdata_i = rd;
      #1;
      chk("ad_req", DW'(ad_req_o), DW'(1));
      chk("ad_id", DW'(ad_id_o), DW'(p));
      chk("ad_addr", DW'(ad_addr_o), DW'(addr_i[p*XLEN +: XLEN]));
      chk("ad_we", DW'(ad_we_o), DW'(we_i[ix(p)]));
      chk("ad_type", DW'(ad_type_o), DW'(type_i[ix(p)]));
      chk("ad_be", DW'(ad_be_o), DW'(be_i[p*BW +: BW]));
      chk("gnt", DW'(gnt_o), DW'((k == gdly) ? oh : '0));
      chk("valid_in_req", DW'(valid_o), DW'((k == gdly && vdly == 0) ? oh : '0));
      if (k == gdly && vdly == 0) chk("rdata", rdata_o, rd);
    end
    if (!keep) req_i[ix(p)] = 1'b0;
    for (int c = 1; c <= vdly; c++) begin
      @(posedge clk); #1;
      ad_gnt_i      = 1'b0;
      cw            = {$urandom, $urandom};
      ad_cw_i       = cw;
      ad_cw_valid_i = (c == cw_at);
      rd            = rand_line();
      ad_rdata_i    = rd;
      ad_valid_i    = (c == vdly);
      ad_id_i       = rid;
      #1;
      chk("ad_req_resp", DW'(ad_req_o), DW'(0));
      chk("gnt_resp", DW'(gnt_o), DW'(0));
      chk("wdata_hold", ad_wdata_o, wdata_i[p*DW +: DW]);
      chk("cw_valid", DW'(critical_word_valid_o), DW'((c == cw_at) ? oh : '0));
      if (c == cw_at) chk("cw_data", DW'(critical_word_o), DW'(cw));
      chk("valid", DW'(valid_o), DW'((c == vdly) ? oh : '0));
      if (c == vdly) chk("rdata", rdata_o, rd);
    end
    rr_m = (p + 1) % NP;
    if (rid != IW'(p)) err_m = 1'b1;
  endtask

  initial begin
    int win, vd, cwa, c;
    rst_ni = 1'b0;
    req_i = '0; type_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0; size_i = '0;
    clr_ad();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ad_req", DW'(ad_req_o), DW'(0));
    chk("rst_gnt", DW'(gnt_o), DW'(0));
    chk("rst_valid", DW'(valid_o), DW'(0));
    chk("rst_cwv", DW'(critical_word_valid_o), DW'(0));
    chk("rst_err", DW'(err_o), DW'(0));
    chk("rst_rdata", rdata_o, DW'(0));
    chk("rst_ad_addr", DW'(ad_addr_o), DW'(0));
    chk("rst_ad_id", DW'(ad_id_o), DW'(0));
    rst_ni = 1'b1;
    #1;

    // Single port 0 read: gnt after 2 cycles, valid 5 cycles later
    set_port(0, 1'b0);
    req_i[0] = 1'b1;
    do_txn(0, 2, 5, -1, IW'(0), 0, 1'b0);

    // All ports requesting continuously: order 0,1,2,0 with one-cycle bubbles
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0);
    req_i = '1;
    do_txn(0, 0, 2, -1, IW'(0), 0, 1'b1);
    do_txn(1, 1, 1, -1, IW'(1), 1, 1'b1);
    do_txn(2, 0, 3, -1, IW'(2), 1, 1'b1);
    do_txn(0, 0, 1, -1, IW'(0), 1, 1'b1);

    // Port 2 line write while port 1 arrives; port 1 follows
    do_reset();
    set_port(2, 1'b1);
    req_i[2] = 1'b1;
    @(posedge clk); #1;
    set_port(1, 1'b0);
    req_i[1] = 1'b1;
    do_txn(2, 1, 4, -1, IW'(2), -1, 1'b0);
    do_txn(1, 0, 2, -1, IW'(1), 1, 1'b0);

    // Critical word for port 1 at beat 0
    do_reset();
    set_port(1, 1'b0);
    req_i[1] = 1'b1;
    do_txn(1, 1, 4, 1, IW'(1), 0, 1'b0);

    // Wrong response ID makes err_o sticky until reset
    do_reset();
    set_port(1, 1'b0);
    req_i[1] = 1'b1;
    do_txn(1, 0, 2, -1, IW'(5), 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("err_sticky", DW'(err_o), DW'(err_m));
    end
    do_reset();
    chk("err_cleared", DW'(err_o), DW'(0));

    // Stray valid in IDLE: no pulse, err_o rises
    @(posedge clk); #1;
    ad_valid_i = 1'b1;
    ad_cw_valid_i = 1'b1;
    ad_rdata_i = rand_line();
    #1;
    chk("idle_valid_pulse", DW'(valid_o), DW'(0));
    chk("idle_cwv_pulse", DW'(critical_word_valid_o), DW'(0));
    idle_cycle();
    chk("idle_valid_err", DW'(err_o), DW'(1));

    // Reset during RESP: no pulses, pointer back to 0
    do_reset();
    set_port(0, 1'b0);
    req_i[0] = 1'b1;
    do_txn(0, 0, 1, -1, IW'(0), 0, 1'b0);
    set_port(1, 1'b0);
    req_i[1] = 1'b1;
    idle_cycle();
    @(posedge clk); #1;
    chk("abort_ad_req", DW'(ad_req_o), DW'(1));
    chk("abort_ad_id", DW'(ad_id_o), DW'(1));
    ad_gnt_i = 1'b1;
    #1;
    chk("abort_gnt", DW'(gnt_o), DW'(3'b010));
    req_i[1] = 1'b0;
    @(posedge clk); #1;
    ad_gnt_i = 1'b0;
    #1;
    chk("abort_in_resp", DW'(ad_req_o), DW'(0));
    @(posedge clk); #1;
    rst_ni = 1'b0;
    ad_valid_i = 1'b1;
    ad_cw_valid_i = 1'b1;
    ad_id_i = IW'(1);
    #1;
    chk("abort_valid", DW'(valid_o), DW'(0));
    chk("abort_cwv", DW'(critical_word_valid_o), DW'(0));
    chk("abort_gnt0", DW'(gnt_o), DW'(0));
    chk("abort_err", DW'(err_o), DW'(0));
    @(posedge clk); #1;
    chk("abort_valid_hold", DW'(valid_o), DW'(0));
    rst_ni = 1'b1;
    clr_ad();
    rr_m = 0;
    err_m = 1'b0;
    #1;
    set_port(0, 1'b0);
    set_port(1, 1'b0);
    req_i = 3'b011;
    do_txn(0, 1, 2, -1, IW'(0), 0, 1'b0);
    do_txn(1, 0, 1, -1, IW'(1), 1, 1'b0);

    // Randomized traffic against the round-robin model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < NP; q++) begin
        if (!req_i[ix(q)] && $urandom_range(0, 1) == 1) begin
          set_port(q, 1'($urandom_range(0, 1)));
          req_i[ix(q)] = 1'b1;
        end
      end
      if (req_i == '0) begin
        c = int'($urandom_range(0, NP - 1));
        set_port(c, 1'b0);
        req_i[ix(c)] = 1'b1;
      end
      win = -1;
      for (int i = 0; i < NP; i++) begin
        c = (rr_m + i) % NP;
        if (win < 0 && req_i[ix(c)]) win = c;
      end
      vd  = int'($urandom_range(0, 4));
      cwa = (vd > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, vd)) : -1;
      do_txn(win, int'($urandom_range(0, 3)), vd, cwa, IW'(win), (t == 0) ? 0 : 1, 1'b0);
    end
    idle_cycle();
    chk("err_after_random", DW'(err_o), DW'(0));
    chk("protocol", DW'(proto_viol), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
